report_tokenizer: RTL and testbench

Front end of the day-2 report pipeline. It accepts the puzzle input as a stream of ASCII characters and converts each whitespace-separated decimal number into the value/strobe/newline triple that the report processors consume. It drives the `read_val`, `en_processor` and `newline` signals shared by every processor instance. It flags the last number of each line with `newline`, so downstream logic never sees a bare line terminator.

---
 rtl/report_pkg.sv | 38 +++
 rtl/decimal_accumulator.sv | 19 +
 rtl/report_tokenizer.sv | 170 +++++++++++++++++
 tb/tb_report_tokenizer.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/report_pkg.sv
// Shared constants, state encoding and character classification for the report tokenizer.
package report_pkg;

    localparam logic [7:0] ASCII_0   = 8'h30;
    localparam logic [7:0] ASCII_9   = 8'h39;
    localparam logic [7:0] ASCII_SP  = 8'h20;
    localparam logic [7:0] ASCII_TAB = 8'h09;
    localparam logic [7:0] ASCII_LF  = 8'h0A;
    localparam logic [7:0] ASCII_CR  = 8'h0D;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NUM  = 2'd1,
        DONE = 2'd2
    } tok_state_t;

    localparam int ERR_ILLEGAL = 0;
    localparam int ERR_OVF     = 1;
    localparam int ERR_TOKENS  = 2;
    localparam int ERR_UNTERM  = 3;

    typedef enum logic [2:0] {
        CLS_DIGIT   = 3'd0,
        CLS_DELIM   = 3'd1,
        CLS_LF      = 3'd2,
        CLS_CR      = 3'd3,
        CLS_ILLEGAL = 3'd4
    } char_class_t;

    function automatic char_class_t classify(input logic [7:0] c);
        if (c >= ASCII_0 && c <= ASCII_9)       return CLS_DIGIT;
        if (c == ASCII_SP || c == ASCII_TAB)    return CLS_DELIM;
        if (c == ASCII_LF)                      return CLS_LF;
        if (c == ASCII_CR)                      return CLS_CR;
        return CLS_ILLEGAL;
    endfunction

endpackage

// File: rtl/decimal_accumulator.sv
// Combinational decimal digit accumulation with saturation at 255.
module decimal_accumulator (
    input  logic [7:0] acc,
    input  logic [3:0] digit,
    input  logic       start,
    output logic [7:0] next_acc,
    output logic       ovf
);

    logic [11:0] sum;

    // 12 bits covers the worst case 255*10+9 without wrapping.
    always_comb begin
        sum      = start ? {8'd0, digit} : (({4'd0, acc} * 12'd10) + {8'd0, digit});
        ovf      = (sum > 12'd255);
        next_acc = ovf ? 8'hFF : sum[7:0];
    end

endmodule

// File: rtl/report_tokenizer.sv
// ASCII stream to value/strobe/newline tokenizer for the report processors.
// Optional TOKENIZER_STATS_EN adds saturating line and token counters.
module report_tokenizer
    import report_pkg::*;
#(
    parameter int MAX_TOKENS = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] char_in,
    input  logic       char_valid,
    input  logic       char_last,
    output logic       char_ready,
    output logic [7:0] read_val,
    output logic       en_processor,
    output logic       newline,
    output logic       done,
    output logic [3:0] err
`ifdef TOKENIZER_STATS_EN
    ,
    output logic [15:0] line_count,
    output logic [15:0] token_count
`endif
);

    localparam int                CNT_W   = $clog2(MAX_TOKENS + 1);
    localparam logic [CNT_W-1:0]  MAX_CNT = CNT_W'(MAX_TOKENS);

    tok_state_t       state_q, state_d;
    logic [7:0]       acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ready_q;
    logic             en_q, en_d;
    logic [7:0]       val_q, val_d;
    logic             nl_q, nl_d;
    logic             done_q, done_d;
    logic [3:0]       err_q, err_d;

    logic             xfer;
    char_class_t      cls;
    logic [7:0]       acc_next;
    logic             acc_ovf;
    logic             emit, emit_nl;
    logic [7:0]       emit_val;

    decimal_accumulator u_acc (
        .acc      (acc_q),
        .digit    (char_in[3:0]),
        .start    (state_q == IDLE),
        .next_acc (acc_next),
        .ovf      (acc_ovf)
    );

    // Ready comes from a register so it stays low throughout reset, not just after it.
    assign char_ready = ready_q && (state_q != DONE);
    assign xfer       = char_valid && char_ready;

    always_comb begin
        // NOTE: every next-state signal takes its hold value first so no path leaves one unassigned (no latch).
        state_d  = state_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        done_d   = done_q;
        emit     = 1'b0;
        emit_nl  = 1'b0;
        emit_val = acc_q;
        cls      = classify(char_in);

        if (xfer) begin
            case (cls)
                CLS_DIGIT: begin
                    acc_d   = acc_next;
                    state_d = NUM;
                    if (acc_ovf) err_d[ERR_OVF] = 1'b1;
                end
                CLS_DELIM, CLS_ILLEGAL: begin
                    if (cls == CLS_ILLEGAL) err_d[ERR_ILLEGAL] = 1'b1;
                    if (state_q == NUM) begin
                        emit    = 1'b1;
                        state_d = IDLE;
                        if (cnt_q == MAX_CNT) err_d[ERR_TOKENS] = 1'b1;
                        else                  cnt_d = cnt_q + 1'b1;
                    end
                end
                CLS_LF: begin
                    if (state_q == NUM) begin
                        emit    = 1'b1;
                        emit_nl = 1'b1;
                        state_d = IDLE;
                        if (cnt_q == MAX_CNT) err_d[ERR_TOKENS] = 1'b1;
                    end else if (cnt_q != '0) begin
                        err_d[ERR_UNTERM] = 1'b1;
                    end
                    cnt_d = '0;
                end
                default: ;
            endcase

            // End of input closes whatever the character above left open.
            if (char_last) begin
                if (state_d == NUM) begin
                    emit     = 1'b1;
                    emit_nl  = 1'b1;
                    emit_val = acc_d;
                    if (cnt_d == MAX_CNT) err_d[ERR_TOKENS] = 1'b1;
                end else if (cnt_d != '0) begin
                    err_d[ERR_UNTERM] = 1'b1;
                end
                cnt_d   = '0;
                state_d = DONE;
                done_d  = 1'b1;
            end
        end

        en_d  = emit;
        val_d = emit ? emit_val : val_q;
        nl_d  = emit_nl;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            en_q    <= 1'b0;
            val_q   <= '0;
            nl_q    <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ready_q <= 1'b1;
            en_q    <= en_d;
            val_q   <= val_d;
            nl_q    <= nl_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign read_val     = val_q;
    assign en_processor = en_q;
    assign newline      = nl_q;
    assign done         = done_q;
    assign err          = err_q;

`ifdef TOKENIZER_STATS_EN
    logic [15:0] line_cnt_q, tok_cnt_q;

    // Counters advance with the emission so they already include the strobe they accompany.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_cnt_q <= '0;
            tok_cnt_q  <= '0;
        end else if (emit) begin
            if (tok_cnt_q != 16'hFFFF) tok_cnt_q <= tok_cnt_q + 16'd1;
            if (emit_nl && line_cnt_q != 16'hFFFF) line_cnt_q <= line_cnt_q + 16'd1;
        end
    end

    assign line_count  = line_cnt_q;
    assign token_count = tok_cnt_q;
`endif

endmodule

// File: tb/tb_report_tokenizer.sv
// Self-checking bench for report_tokenizer: directed vectors, timing cases and random streams
// compared against a line/word based reference model.
module tb_report_tokenizer;

    localparam int MAX_TOKENS = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] char_in = 8'h00;
    logic       char_valid = 1'b0;
    logic       char_last = 1'b0;
    logic       char_ready;
    logic [7:0] read_val;
    logic       en_processor;
    logic       newline;
    logic       done;
    logic [3:0] err;
`ifdef TOKENIZER_STATS_EN
    logic [15:0] line_count;
    logic [15:0] token_count;
`endif

    report_tokenizer #(.MAX_TOKENS(MAX_TOKENS)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .char_in      (char_in),
        .char_valid   (char_valid),
        .char_last    (char_last),
        .char_ready   (char_ready),
        .read_val     (read_val),
        .en_processor (en_processor),
        .newline      (newline),
        .done         (done),
        .err          (err)
`ifdef TOKENIZER_STATS_EN
        ,
        .line_count   (line_count),
        .token_count  (token_count)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;
    int last_acc_cyc = 0;

    // Observed strobes, sampled on the falling edge.
    logic [7:0] mon_val[$];
    logic       mon_nl[$];
    int         mon_cyc[$];
    logic       mon_done[$];

    always @(negedge clk) begin
        if (en_processor) begin
            mon_val.push_back(read_val);
            mon_nl.push_back(newline);
            mon_cyc.push_back(cyc);
            mon_done.push_back(done);
        end
    end

    // Stimulus and expected results.
    logic [7:0] stim[$];
    logic [7:0] mline[$];
    logic [7:0] exp_val[$];
    logic       exp_nl[$];
    logic [3:0] exp_err;

    function automatic bit is_digit(input logic [7:0] c);
        return (c >= 8'h30 && c <= 8'h39);
    endfunction

    // Split one line into words; each word becomes one expected strobe.
    task automatic model_line();
        int  words[$];
        int  v = 0;
        bit  in_word = 0;
        for (int i = 0; i < mline.size(); i++) begin
            if (is_digit(mline[i])) begin
                v = in_word ? v * 10 + int'(mline[i] - 8'h30) : int'(mline[i] - 8'h30);
                if (v > 255) begin
                    exp_err[1] = 1'b1;
                    v = 256;
                end
                in_word = 1;
            end else if (in_word) begin
                words.push_back(v);
                in_word = 0;
            end
        end
        if (in_word) words.push_back(v);
        for (int i = 0; i < words.size(); i++) begin
            exp_val.push_back(words[i] > 255 ? 8'd255 : 8'(words[i]));
            exp_nl.push_back((i == words.size() - 1) && in_word);
        end
        if (words.size() > 0 && !in_word) exp_err[3] = 1'b1;
        if (words.size() > MAX_TOKENS)    exp_err[2] = 1'b1;
    endtask

    // Whole-input model: drop CR, map illegal characters to spaces, then process line by line.
    task automatic model();
        logic [7:0] c;
        exp_val.delete();
        exp_nl.delete();
        exp_err = 4'b0000;
        mline.delete();
        for (int i = 0; i < stim.size(); i++) begin
            c = stim[i];
            if (c == 8'h0D) begin
            end else if (c == 8'h0A) begin
                model_line();
                mline.delete();
            end else if (is_digit(c)) begin
                mline.push_back(c);
            end else begin
                if (c != 8'h20 && c != 8'h09) exp_err[0] = 1'b1;
                mline.push_back(8'h20);
            end
        end
        model_line();
        mline.delete();
    endtask

    task automatic load(input string s);
        stim.delete();
        for (int i = 0; i < s.len(); i++) stim.push_back(s[i]);
    endtask

    task automatic clear_mon();
        mon_val.delete();
        mon_nl.delete();
        mon_cyc.delete();
        mon_done.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n      = 1'b0;
        char_valid = 1'b0;
        char_last  = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        clear_mon();
    endtask

    // Called at a falling edge; returns at the falling edge after the transfer.
    task automatic send_char(input logic [7:0] c, input bit last, input int gap);
        bit sent = 0;
        char_valid = 1'b0;
        char_last  = 1'b0;
        repeat (gap) @(negedge clk);
        char_in    = c;
        char_valid = 1'b1;
        char_last  = last;
        for (int w = 0; w < 20 && !sent; w++) begin
            if (char_ready) begin
                last_acc_cyc = cyc;
                sent = 1;
            end
            @(negedge clk);
        end
        if (!sent) begin
            n_checks++;
            n_fail++;
            $display("FAIL ready_timeout: char_ready stayed %b, required 1 within 20 cycles", char_ready);
        end
        char_valid = 1'b0;
        char_last  = 1'b0;
    endtask

    task automatic run_stream(input bit gaps);
        for (int i = 0; i < stim.size(); i++)
            send_char(stim[i], i == stim.size() - 1, gaps ? $urandom_range(0, 2) : 0);
        repeat (4) @(negedge clk);
    endtask

    task automatic check_stream(input string name);
        n_checks++;
        if (mon_val.size() !== exp_val.size()) begin
            n_fail++;
            $display("FAIL %s strobe_count: got %0d required %0d", name, mon_val.size(), exp_val.size());
        end
        for (int i = 0; i < mon_val.size() && i < exp_val.size(); i++) begin
            n_checks++;
            if (mon_val[i] !== exp_val[i] || mon_nl[i] !== exp_nl[i]) begin
                n_fail++;
                $display("FAIL %s strobe[%0d]: got %0d/nl=%b required %0d/nl=%b",
                         name, i, mon_val[i], mon_nl[i], exp_val[i], exp_nl[i]);
            end
        end
        n_checks++;
        if (err !== exp_err) begin
            n_fail++;
            $display("FAIL %s err: got %b required %b", name, err, exp_err);
        end
        n_checks++;
        if (done !== 1'b1 || char_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL %s done_state: got done=%b ready=%b required done=1 ready=0", name, done, char_ready);
        end
`ifdef TOKENIZER_STATS_EN
        begin
            int nl_cnt = 0;
            foreach (exp_nl[i]) if (exp_nl[i]) nl_cnt++;
            n_checks++;
            if (line_count !== 16'(nl_cnt) || token_count !== 16'(exp_val.size())) begin
                n_fail++;
                $display("FAIL %s stats: got lines=%0d tokens=%0d required lines=%0d tokens=%0d",
                         name, line_count, token_count, nl_cnt, exp_val.size());
            end
        end
`endif
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({char_ready, read_val, en_processor, newline, done, err} !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_outputs: got ready=%b val=%0d en=%b nl=%b done=%b err=%b required all 0",
                     char_ready, read_val, en_processor, newline, done, err);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (char_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready: got %b required 1", char_ready);
        end
    endtask

    task automatic test_vector(input string name, input string s, input logic [3:0] want_err);
        do_reset();
        load(s);
        model();
        run_stream(1'b0);
        check_stream(name);
        n_checks++;
        if (err !== want_err) begin
            n_fail++;
            $display("FAIL %s err_direct: got %b required %b", name, err, want_err);
        end
    endtask

    task automatic test_plan_vectors();
        string s16, s17;
        test_vector("plan_two_lines", "7 6 4 2 1\n1 2 7 8 9\n", 4'b0000);
        test_vector("plan_overflow",  "300 5\n",                4'b0010);
        test_vector("plan_illegal",   "1 x2\n",                 4'b0001);
        test_vector("plan_unterm",    "4 5 \n6\n",              4'b1000);
        s16 = "";
        for (int i = 1; i <= MAX_TOKENS; i++) s16 = {s16, $sformatf("%0d", i), (i == MAX_TOKENS) ? "\n" : " "};
        s17 = {"9 ", s16};
        test_vector("max_tokens_ok",   s16, 4'b0000);
        test_vector("max_tokens_over", s17, 4'b0100);
    endtask

    task automatic test_done_timing();
        test_vector("plan_cr_blank", "12\r\n\n3", 4'b0000);
        n_checks++;
        if (mon_done.size() != 2 || mon_done[0] !== 1'b0 || mon_done[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL done_with_strobe: got %0d strobes, done flags %p required 2 strobes with done 0 then 1",
                     mon_done.size(), mon_done);
        end
    endtask

    task automatic test_back_to_back();
        int t1, t2;
        do_reset();
        load("5 6\n");
        model();
        send_char(8'h35, 0, 0);
        send_char(8'h20, 0, 0);
        t1 = last_acc_cyc;
        send_char(8'h36, 0, 0);
        send_char(8'h0A, 1, 0);
        t2 = last_acc_cyc;
        repeat (4) @(negedge clk);
        check_stream("back_to_back");
        n_checks++;
        if (mon_cyc.size() != 2 || mon_cyc[0] != t1 + 1 || mon_cyc[1] != t2 + 1) begin
            n_fail++;
            $display("FAIL strobe_latency: got cycles %p required %0d and %0d", mon_cyc, t1 + 1, t2 + 1);
        end
    endtask

    task automatic test_reset_midline();
        do_reset();
        send_char(8'h31, 0, 0);
        send_char(8'h32, 0, 0);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (en_processor !== 1'b0 || err !== 4'b0000) begin
            n_fail++;
            $display("FAIL midline_reset_outputs: got en=%b err=%b required en=0 err=0000", en_processor, err);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_char(8'h39, 0, 0);
        send_char(8'h0A, 1, 0);
        repeat (4) @(negedge clk);
        n_checks++;
        if (mon_val.size() != 1 || mon_val[0] !== 8'd9 || mon_nl[0] !== 1'b1 || err !== 4'b0000) begin
            n_fail++;
            $display("FAIL midline_reset: got %0d strobes first=%0d err=%b required one strobe 9/nl=1 err=0000",
                     mon_val.size(), (mon_val.size() > 0) ? mon_val[0] : 8'd0, err);
        end
    endtask

    function automatic logic [7:0] rand_char();
        int r = $urandom_range(0, 99);
        if (r < 55) return 8'h30 + 8'($urandom_range(0, 9));
        if (r < 70) return 8'h20;
        if (r < 73) return 8'h09;
        if (r < 85) return 8'h0A;
        if (r < 89) return 8'h0D;
        case ($urandom_range(0, 3))
            0:       return 8'h78;
            1:       return 8'h2C;
            2:       return 8'h2D;
            default: return 8'h41;
        endcase
    endfunction

    task automatic test_random();
        for (int t = 0; t < 30; t++) begin
            do_reset();
            stim.delete();
            for (int i = 0; i < $urandom_range(1, 60); i++) stim.push_back(rand_char());
            model();
            run_stream(1'b1);
            check_stream($sformatf("random_%0d", t));
        end
    endtask

    initial begin
        test_reset();
        test_plan_vectors();
        test_done_timing();
        test_back_to_back();
        test_reset_midline();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
